lsu_mem_unit: RTL and testbench

Load/store execution unit at the far end of the LS reservation-station dispatch interface. It accepts up to two dispatched memory ops per cycle and holds stores in an in-order store buffer until the ROB commits them, then writes them to the internal data memory. Loads read memory, with forwarding from buffered stores, and broadcast their results on the two load-result buses that feed the reservation stations and ROB. It also reports store completion so the ROB can mark stores ready to commit.

---
 rtl/lsu_mem_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_lsu_mem_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_unit.sv
// Dual-lane load/store unit: in-order store buffer, commit-driven memory writes; LSU_FWD_EN selects store-to-load forwarding vs. load hold.
// Load/store results one cycle after dispatch; backpressure is sb_full and ld_wait, both of which the RS must honour.
module lsu_mem_unit #(
    parameter int DEPTH    = 1024,
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp1,
    input  logic        disp2,
    input  logic        mem_write_in1,
    input  logic        mem_write_in2,
    input  logic [31:0] address_in1,
    input  logic [31:0] address_in2,
    input  logic [31:0] data_in1,
    input  logic [31:0] data_in2,
    input  logic [4:0]  dest_in1,
    input  logic [4:0]  dest_in2,
    input  logic [4:0]  sw_tag_in1,
    input  logic [4:0]  sw_tag_in2,
    input  logic        commit_st1,
    input  logic        commit_st2,
    output logic        ld_write,
    output logic        ld_write2,
    output logic [4:0]  ld_tag,
    output logic [4:0]  ld_tag2,
    output logic [31:0] ld_res,
    output logic [31:0] ld_res2,
    output logic        st_done1,
    output logic        st_done2,
    output logic [4:0]  st_tag1,
    output logic [4:0]  st_tag2,
    output logic        sb_full,
    output logic        ld_wait
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [AW-1:0] word;
        logic [31:0]   data;
        logic [4:0]    tag;
    } sb_entry_t;

    sb_entry_t [SB_DEPTH-1:0] sb_q, sb_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, head1;
    logic [PW:0]   count_q, count_d, free, ncom;
    logic [31:0]   mem_q [DEPTH];

    logic        ld1_vld_q, ld1_vld_d, ld2_vld_q, ld2_vld_d;
    logic [4:0]  ld1_tag_q, ld1_tag_d, ld2_tag_q, ld2_tag_d;
    logic [31:0] ld1_res_q, ld1_res_d, ld2_res_q, ld2_res_d;
    logic        st1_vld_q, st1_vld_d, st2_vld_q, st2_vld_d;
    logic [4:0]  st1_tag_q, st1_tag_d, st2_tag_q, st2_tag_d;

    logic [AW-1:0] word1, word2;
    logic          ld1, ld2, acc1, acc2, fwd12, wr0_vld, wr1_vld;
    sb_entry_t     wr0, wr1;
    logic          unused_addr_bits;

    assign word1 = address_in1[AW+1:2];
    assign word2 = address_in2[AW+1:2];
    assign unused_addr_bits = ^{address_in1[31:AW+2], address_in1[1:0],
                                address_in2[31:AW+2], address_in2[1:0]};
    assign ld1   = disp1 && !mem_write_in1;
    assign ld2   = disp2 && !mem_write_in2;
    assign fwd12 = acc1 && (word1 == word2);

    // Free space uses registered count only, so an enqueue never lands on a live entry.
    always_comb begin
        sb_d      = sb_q;
        free      = (PW+1)'(SB_DEPTH) - count_q;
        acc1      = disp1 && mem_write_in1 && (free != '0);
        acc2      = disp2 && mem_write_in2 && (free > (PW+1)'(acc1));
        ncom      = (PW+1)'(commit_st1) + (PW+1)'(commit_st2);
        if (ncom > count_q) ncom = count_q;
        head1     = head_q + PW'(1);
        wr0_vld   = (ncom != '0);
        wr1_vld   = (ncom == (PW+1)'(2));
        wr0       = sb_q[head_q];
        wr1       = sb_q[head1];
        head_d    = head_q + ncom[PW-1:0];
        tail_d    = tail_q;
        if (acc1) begin
            sb_d[tail_d] = '{word: word1, data: data_in1, tag: sw_tag_in1};
            tail_d       = tail_d + PW'(1);
        end
        if (acc2) begin
            sb_d[tail_d] = '{word: word2, data: data_in2, tag: sw_tag_in2};
            tail_d       = tail_d + PW'(1);
        end
        count_d   = count_q + (PW+1)'(acc1) + (PW+1)'(acc2) - ncom;
        st1_vld_d = acc1;
        st1_tag_d = acc1 ? sw_tag_in1 : 5'd0;
        st2_vld_d = acc2;
        st2_tag_d = acc2 ? sw_tag_in2 : 5'd0;
    end

`ifdef LSU_FWD_EN
    // Youngest live entry wins; entries committing this cycle are still live.
    function automatic logic [31:0] sb_read(input sb_entry_t [SB_DEPTH-1:0] sb,
                                            input logic [PW-1:0] head, input logic [PW:0] cnt,
                                            input logic [AW-1:0] w, input logic [31:0] dflt);
        logic [31:0]   r;
        logic [PW-1:0] idx;
        r = dflt;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head + PW'(i);
            if (((PW+1)'(i) < cnt) && (sb[idx].word == w)) r = sb[idx].data;
        end
        return r;
    endfunction

    always_comb begin
        ld1_vld_d = ld1;
        ld1_tag_d = ld1 ? dest_in1 : 5'd0;
        ld1_res_d = ld1 ? sb_read(sb_q, head_q, count_q, word1, mem_q[word1]) : 32'd0;
        ld2_vld_d = ld2;
        ld2_tag_d = ld2 ? dest_in2 : 5'd0;
        ld2_res_d = 32'd0;
        if (ld2) ld2_res_d = fwd12 ? data_in1 : sb_read(sb_q, head_q, count_q, word2, mem_q[word2]);
    end

    assign ld_wait = 1'b0;
`else
    function automatic logic sb_hit(input sb_entry_t [SB_DEPTH-1:0] sb,
                                    input logic [PW-1:0] head, input logic [PW:0] cnt,
                                    input logic [AW-1:0] w);
        logic          h;
        logic [PW-1:0] idx;
        h = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head + PW'(i);
            if (((PW+1)'(i) < cnt) && (sb[idx].word == w)) h = 1'b1;
        end
        return h;
    endfunction

    logic          h1_vld_q, h1_vld_d, h2_vld_q, h2_vld_d;
    logic [AW-1:0] h1_word_q, h1_word_d, h2_word_q, h2_word_d;
    logic [4:0]    h1_tag_q, h1_tag_d, h2_tag_q, h2_tag_d;

    // One hold slot per lane; a held load drains on its own lane once the buffer no longer matches.
    always_comb begin
        h1_vld_d = h1_vld_q; h1_word_d = h1_word_q; h1_tag_d = h1_tag_q;
        h2_vld_d = h2_vld_q; h2_word_d = h2_word_q; h2_tag_d = h2_tag_q;
        ld1_vld_d = 1'b0; ld1_tag_d = 5'd0; ld1_res_d = 32'd0;
        ld2_vld_d = 1'b0; ld2_tag_d = 5'd0; ld2_res_d = 32'd0;
        if (h1_vld_q && !sb_hit(sb_q, head_q, count_q, h1_word_q)) begin
            h1_vld_d = 1'b0;
            ld1_vld_d = 1'b1; ld1_tag_d = h1_tag_q; ld1_res_d = mem_q[h1_word_q];
        end
        if (h2_vld_q && !sb_hit(sb_q, head_q, count_q, h2_word_q)) begin
            h2_vld_d = 1'b0;
            ld2_vld_d = 1'b1; ld2_tag_d = h2_tag_q; ld2_res_d = mem_q[h2_word_q];
        end
        if (ld1) begin
            if (sb_hit(sb_q, head_q, count_q, word1)) begin
                h1_vld_d = 1'b1; h1_word_d = word1; h1_tag_d = dest_in1;
            end else begin
                ld1_vld_d = 1'b1; ld1_tag_d = dest_in1; ld1_res_d = mem_q[word1];
            end
        end
        if (ld2) begin
            if (fwd12 || sb_hit(sb_q, head_q, count_q, word2)) begin
                h2_vld_d = 1'b1; h2_word_d = word2; h2_tag_d = dest_in2;
            end else begin
                ld2_vld_d = 1'b1; ld2_tag_d = dest_in2; ld2_res_d = mem_q[word2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h1_vld_q <= 1'b0; h1_word_q <= '0; h1_tag_q <= '0;
            h2_vld_q <= 1'b0; h2_word_q <= '0; h2_tag_q <= '0;
        end else begin
            h1_vld_q <= h1_vld_d; h1_word_q <= h1_word_d; h1_tag_q <= h1_tag_d;
            h2_vld_q <= h2_vld_d; h2_word_q <= h2_word_d; h2_tag_q <= h2_tag_d;
        end
    end

    assign ld_wait = h1_vld_q || h2_vld_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q <= '0; head_q <= '0; tail_q <= '0; count_q <= '0;
            ld1_vld_q <= 1'b0; ld1_tag_q <= '0; ld1_res_q <= '0;
            ld2_vld_q <= 1'b0; ld2_tag_q <= '0; ld2_res_q <= '0;
            st1_vld_q <= 1'b0; st1_tag_q <= '0;
            st2_vld_q <= 1'b0; st2_tag_q <= '0;
        end else begin
            sb_q <= sb_d; head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
            ld1_vld_q <= ld1_vld_d; ld1_tag_q <= ld1_tag_d; ld1_res_q <= ld1_res_d;
            ld2_vld_q <= ld2_vld_d; ld2_tag_q <= ld2_tag_d; ld2_res_q <= ld2_res_d;
            st1_vld_q <= st1_vld_d; st1_tag_q <= st1_tag_d;
            st2_vld_q <= st2_vld_d; st2_tag_q <= st2_tag_d;
        end
    end

    // Second write lands last, so the younger of two same-word commits wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr0_vld) mem_q[wr0.word] <= wr0.data;
            if (wr1_vld) mem_q[wr1.word] <= wr1.data;
        end
    end

    assign ld_write  = ld1_vld_q;
    assign ld_tag    = ld1_tag_q;
    assign ld_res    = ld1_res_q;
    assign ld_write2 = ld2_vld_q;
    assign ld_tag2   = ld2_tag_q;
    assign ld_res2   = ld2_res_q;
    assign st_done1  = st1_vld_q;
    assign st_tag1   = st1_tag_q;
    assign st_done2  = st2_vld_q;
    assign st_tag2   = st2_tag_q;
    assign sb_full   = count_q > (PW+1)'(SB_DEPTH - 2);
endmodule

// File: tb/tb_lsu_mem_unit.sv
// Directed bench for lsu_mem_unit (SB_DEPTH = 4); covers both LSU_FWD_EN builds.
module tb_lsu_mem_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        disp1, disp2, mem_write_in1, mem_write_in2, commit_st1, commit_st2;
    logic [31:0] address_in1, address_in2, data_in1, data_in2;
    logic [4:0]  dest_in1, dest_in2, sw_tag_in1, sw_tag_in2;
    logic        ld_write, ld_write2, st_done1, st_done2, sb_full, ld_wait;
    logic [4:0]  ld_tag, ld_tag2, st_tag1, st_tag2;
    logic [31:0] ld_res, ld_res2;

    int n_run  = 0;
    int n_fail = 0;

    lsu_mem_unit #(.DEPTH(1024), .SB_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .disp1(disp1), .disp2(disp2),
        .mem_write_in1(mem_write_in1), .mem_write_in2(mem_write_in2),
        .address_in1(address_in1), .address_in2(address_in2),
        .data_in1(data_in1), .data_in2(data_in2),
        .dest_in1(dest_in1), .dest_in2(dest_in2),
        .sw_tag_in1(sw_tag_in1), .sw_tag_in2(sw_tag_in2),
        .commit_st1(commit_st1), .commit_st2(commit_st2),
        .ld_write(ld_write), .ld_write2(ld_write2),
        .ld_tag(ld_tag), .ld_tag2(ld_tag2),
        .ld_res(ld_res), .ld_res2(ld_res2),
        .st_done1(st_done1), .st_done2(st_done2),
        .st_tag1(st_tag1), .st_tag2(st_tag2),
        .sb_full(sb_full), .ld_wait(ld_wait)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clr();
        disp1 = 0; disp2 = 0; mem_write_in1 = 0; mem_write_in2 = 0;
        address_in1 = 0; address_in2 = 0; data_in1 = 0; data_in2 = 0;
        dest_in1 = 0; dest_in2 = 0; sw_tag_in1 = 0; sw_tag_in2 = 0;
        commit_st1 = 0; commit_st2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op1(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [4:0] t);
        disp1 = 1; mem_write_in1 = wr; address_in1 = a; data_in1 = d; dest_in1 = t; sw_tag_in1 = t;
    endtask

    task automatic op2(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [4:0] t);
        disp2 = 1; mem_write_in2 = wr; address_in2 = a; data_in2 = d; dest_in2 = t; sw_tag_in2 = t;
    endtask

    initial begin
        rst = 0;
        clr();
        #12;
        check("rst_ld_write", ld_write, 0);
        check("rst_st_done1", st_done1, 0);
        check("rst_sb_full", sb_full, 0);
        check("rst_ld_wait", ld_wait, 0);
        #10 rst = 1;
        tick();

        // Plain load from cleared memory, one-cycle pulse
        op1(0, 32'h40, 0, 5'd7); tick(); clr();
        check("ld0_write", ld_write, 1);
        check("ld0_tag", ld_tag, 7);
        check("ld0_res", ld_res, 0);
        check("ld0_write2", ld_write2, 0);
        check("ld0_st_done1", st_done1, 0);
        tick();
        check("ld0_pulse", ld_write, 0);

        // Store, commit at N+2, load at N+3
        op1(1, 32'h40, 32'hDEAD, 5'd3); tick(); clr();
        check("st_done1", st_done1, 1);
        check("st_tag1", st_tag1, 3);
        tick();
        commit_st1 = 1; tick(); clr();
        check("st_done1_pulse", st_done1, 0);
        op1(0, 32'h40, 0, 5'd9); tick(); clr();
        check("ldc_write", ld_write, 1);
        check("ldc_tag", ld_tag, 9);
        check("ldc_res", ld_res, 32'hDEAD);

        // Two buffered stores to 0x80 then a load
        op1(1, 32'h80, 32'h11, 5'd4); tick(); clr();
        op1(1, 32'h80, 32'h22, 5'd5); tick(); clr();
        check("st2x_tag", st_tag1, 5);
        op1(0, 32'h80, 0, 5'd10); tick(); clr();
`ifdef LSU_FWD_EN
        check("fwd_write", ld_write, 1);
        check("fwd_res", ld_res, 32'h22);
        commit_st1 = 1; commit_st2 = 1; tick(); clr();
        op1(0, 32'h80, 0, 5'd10); tick(); clr();
        check("fwd_mem_res", ld_res, 32'h22);
`else
        check("hold_write", ld_write, 0);
        check("hold_wait", ld_wait, 1);
        commit_st1 = 1; tick(); clr();
        check("hold_wait_c1", ld_wait, 1);
        check("hold_write_c1", ld_write, 0);
        commit_st1 = 1; tick(); clr();
        check("hold_wait_c2", ld_wait, 1);
        check("hold_write_c2", ld_write, 0);
        tick();
        check("hold_rel_write", ld_write, 1);
        check("hold_rel_tag", ld_tag, 10);
        check("hold_rel_res", ld_res, 32'h22);
        check("hold_rel_wait", ld_wait, 0);
`endif

        // Lane-1 store feeding a lane-2 load in the same pair
        op1(1, 32'h100, 32'h55, 5'd6); op2(0, 32'h100, 0, 5'd11); tick(); clr();
        check("pair_st_done1", st_done1, 1);
        check("pair_st_tag1", st_tag1, 6);
`ifdef LSU_FWD_EN
        check("pair_write2", ld_write2, 1);
        check("pair_res2", ld_res2, 32'h55);
        check("pair_tag2", ld_tag2, 11);
        commit_st1 = 1; tick(); clr();
        check("pair_pulse2", ld_write2, 0);
`else
        check("pair_write2", ld_write2, 0);
        check("pair_wait", ld_wait, 1);
        commit_st1 = 1; tick(); clr();
        check("pair_wait_c", ld_wait, 1);
        tick();
        check("pair_rel_write2", ld_write2, 1);
        check("pair_rel_res2", ld_res2, 32'h55);
        check("pair_rel_tag2", ld_tag2, 11);
        check("pair_rel_write1", ld_write, 0);
`endif

        // Fill to count 3, then dual commit alongside one store
        op1(1, 32'h200, 32'd1, 5'd1); op2(1, 32'h204, 32'd2, 5'd2); tick(); clr();
        check("fill_st_done2", st_done2, 1);
        check("fill_st_tag2", st_tag2, 2);
        check("fill_cnt2_full", sb_full, 0);
        op1(1, 32'h208, 32'd3, 5'd8); tick(); clr();
        check("fill_cnt3_full", sb_full, 1);
        op1(1, 32'h20C, 32'd4, 5'd12); commit_st1 = 1; commit_st2 = 1; tick(); clr();
        check("fill_enq_commit_done", st_done1, 1);
        check("fill_enq_commit_tag", st_tag1, 12);
        check("fill_cnt2_after", sb_full, 0);
        commit_st1 = 1; commit_st2 = 1; tick(); clr();
        op1(0, 32'h208, 0, 5'd2); op2(0, 32'h20C, 0, 5'd3); tick(); clr();
        check("fill_ld1_res", ld_res, 3);
        check("fill_ld2_res", ld_res2, 4);
        check("fill_ld2_write", ld_write2, 1);

        // Same-word pair committed together: younger wins
        op1(1, 32'h300, 32'h7, 5'd13); op2(1, 32'h300, 32'h9, 5'd14); tick(); clr();
        check("sw_st_tag2", st_tag2, 14);
        commit_st1 = 1; commit_st2 = 1; tick(); clr();
        op1(0, 32'h300, 0, 5'd1); tick(); clr();
        check("sw_res", ld_res, 32'h9);

        // Commit with an empty buffer is ignored
        commit_st1 = 1; commit_st2 = 1; tick(); clr();
        tick();
        check("empty_commit_full", sb_full, 0);
        op1(1, 32'h600, 32'h1, 5'd1); op2(1, 32'h604, 32'h2, 5'd2); tick(); clr();
        check("empty_commit_done2", st_done2, 1);
        check("empty_commit_cnt", sb_full, 0);
        commit_st1 = 1; commit_st2 = 1; tick(); clr();

        // Reset mid-operation
        op1(1, 32'h500, 32'hAB, 5'd4); tick(); clr();
        op1(0, 32'h40, 0, 5'd5); op2(1, 32'h400, 32'h77, 5'd7);
        #1 rst = 0;
        tick(); clr();
        check("mrst_ld_write", ld_write, 0);
        check("mrst_st_done2", st_done2, 0);
        check("mrst_sb_full", sb_full, 0);
        #2 rst = 1;
        tick();
        check("mrst_idle_write", ld_write, 0);
        op1(0, 32'h500, 0, 5'd6); op2(0, 32'h40, 0, 5'd8); tick(); clr();
        check("mrst_ld_write1", ld_write, 1);
        check("mrst_ld_res1", ld_res, 0);
        check("mrst_ld_res2", ld_res2, 0);
        check("mrst_ld_wait", ld_wait, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
